// File: rtl/uart_tx.sv
// UART transmitter: AXI-Stream words out on tx_o as start, data LSB first, optional parity, stop bit(s).
// Latency: a word accepted at edge E0 drives the start bit from E1; each frame is (1+DW+PE+SB)*CLK_DIV cycles.
// Backpressure: tready drops while the one-entry holding register is full; one word can wait during a frame.
module uart_tx #(
    parameter int DATA_WIDTH = 8,
    parameter int CLK_DIV    = 16,
    parameter int PARITY_EN  = 1,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [DATA_WIDTH-1:0] slv_axis_tdata_i,
    input  logic                  slv_axis_tvalid_i,
    output logic                  slv_axis_tready_o,
    output logic                  tx_o,
    output logic                  busy_o
);
    localparam int BAUD_W = $clog2(CLK_DIV + 1);
    localparam int CNT_W  = $clog2(DATA_WIDTH + 1);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0]  DATA_LAST = CNT_W'(DATA_WIDTH - 1);
    localparam logic [CNT_W-1:0]  STOP_LAST = CNT_W'(STOP_BITS - 1);
    localparam logic              PAR_INV   = (PARITY_ODD != 0);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t                state, state_n;
    logic [DATA_WIDTH-1:0] hold;
    logic [DATA_WIDTH-1:0] shift, shift_n;
    logic                  hold_valid, hold_valid_n;
    logic                  parity, parity_n;
    logic [BAUD_W-1:0]     baud_cnt, baud_cnt_n;
    logic [CNT_W-1:0]      bit_cnt, bit_cnt_n;
    logic                  tx_n, busy_n;
    logic                  accept, load, bit_end;

    assign slv_axis_tready_o = ~hold_valid & ~rst_i;
    assign accept            = slv_axis_tvalid_i & slv_axis_tready_o;
    assign bit_end           = (baud_cnt == BAUD_LAST);

    always_comb begin
        state_n    = state;
        shift_n    = shift;
        parity_n   = parity;
        baud_cnt_n = baud_cnt;
        bit_cnt_n  = bit_cnt;
        load       = 1'b0;
        if (state != IDLE) begin
            baud_cnt_n = bit_end ? '0 : baud_cnt + 1'b1;
        end
        case (state)
            IDLE:  load = hold_valid;
            START: begin
                if (bit_end) begin
                    state_n   = DATA;
                    bit_cnt_n = '0;
                end
            end
            DATA: begin
                if (bit_end) begin
                    shift_n = shift >> 1;
                    if (bit_cnt == DATA_LAST) begin
                        bit_cnt_n = '0;
                        state_n   = (PARITY_EN != 0) ? PARITY : STOP;
                    end else begin
                        bit_cnt_n = bit_cnt + 1'b1;
                    end
                end
            end
            PARITY: begin
                if (bit_end) state_n = STOP;
            end
            STOP: begin
                // bit_cnt is reused to count stop bits
                if (bit_end) begin
                    if (bit_cnt == STOP_LAST) begin
                        bit_cnt_n = '0;
                        state_n   = IDLE;
                        load      = hold_valid;
                    end else begin
                        bit_cnt_n = bit_cnt + 1'b1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
        if (load) begin
            state_n    = START;
            shift_n    = hold;
            parity_n   = (^hold) ^ PAR_INV;
            baud_cnt_n = '0;
        end
        hold_valid_n = (hold_valid & ~load) | accept;
        case (state_n)
            START:   tx_n = 1'b0;
            DATA:    tx_n = shift_n[0];
            PARITY:  tx_n = parity_n;
            default: tx_n = 1'b1;
        endcase
        busy_n = (state_n != IDLE) | hold_valid_n;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state      <= IDLE;
            hold       <= '0;
            hold_valid <= 1'b0;
            shift      <= '0;
            parity     <= 1'b0;
            baud_cnt   <= '0;
            bit_cnt    <= '0;
            tx_o       <= 1'b1;
            busy_o     <= 1'b0;
        end else begin
            state      <= state_n;
            shift      <= shift_n;
            hold_valid <= hold_valid_n;
            parity     <= parity_n;
            baud_cnt   <= baud_cnt_n;
            bit_cnt    <= bit_cnt_n;
            tx_o       <= tx_n;
            busy_o     <= busy_n;
            if (accept) hold <= slv_axis_tdata_i;
        end
    end
endmodule

// File: tb/tb_uart_tx.sv
// Directed frame vectors on four parameterisations of uart_tx, back-to-back and reset corner cases,
// and a random loopback through a receiver model on the even-parity CLK_DIV=4 instance.
module tb_uart_tx;
    logic       clk;
    logic       rst;
    logic [7:0] tdata  [4];
    logic       tvalid [4];
    logic       tready [4];
    logic       tx     [4];
    logic       busy   [4];
    int         divs   [4];
    int         checks;
    int         errors;
    int         rx_cnt;
    logic       rx_en;
    logic [7:0] sent_q [$];

    typedef struct {
        int          u;
        logic [7:0]  d;
        logic [11:0] exp;
        int          nbits;
        string       name;
    } vec_t;
    vec_t vecs [13];

    // u0: even parity, u1: odd parity, u2: no parity, u3: CLK_DIV=1 with two stop bits
    uart_tx #(.DATA_WIDTH(8), .CLK_DIV(4)) u0 (
        .clk_i(clk), .rst_i(rst), .slv_axis_tdata_i(tdata[0]), .slv_axis_tvalid_i(tvalid[0]),
        .slv_axis_tready_o(tready[0]), .tx_o(tx[0]), .busy_o(busy[0]));
    uart_tx #(.DATA_WIDTH(8), .CLK_DIV(4), .PARITY_ODD(1)) u1 (
        .clk_i(clk), .rst_i(rst), .slv_axis_tdata_i(tdata[1]), .slv_axis_tvalid_i(tvalid[1]),
        .slv_axis_tready_o(tready[1]), .tx_o(tx[1]), .busy_o(busy[1]));
    uart_tx #(.DATA_WIDTH(8), .CLK_DIV(4), .PARITY_EN(0)) u2 (
        .clk_i(clk), .rst_i(rst), .slv_axis_tdata_i(tdata[2]), .slv_axis_tvalid_i(tvalid[2]),
        .slv_axis_tready_o(tready[2]), .tx_o(tx[2]), .busy_o(busy[2]));
    uart_tx #(.DATA_WIDTH(8), .CLK_DIV(1), .STOP_BITS(2)) u3 (
        .clk_i(clk), .rst_i(rst), .slv_axis_tdata_i(tdata[3]), .slv_axis_tvalid_i(tvalid[3]),
        .slv_axis_tready_o(tready[3]), .tx_o(tx[3]), .busy_o(busy[3]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_ready(input int u, input string name);
        int n = 0;
        while (tready[u] !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk({name, " tready"}, tready[u], 1);
    endtask

    // exp[11] is the first bit on the line
    task automatic send_check(input int u, input logic [7:0] d, input logic [11:0] exp,
                              input int nbits, input string name);
        int div = divs[u];
        @(negedge clk);
        wait_ready(u, name);
        tdata[u]  = d;
        tvalid[u] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        tvalid[u] = 1'b0;
        chk({name, " idle before start"}, tx[u], 1);
        for (int c = 0; c < nbits * div; c++) begin
            @(negedge clk);
            chk($sformatf("%s c=%0d", name, c), tx[u], exp[11 - c / div]);
            if (c == 0) begin
                chk({name, " busy"}, busy[u], 1);
                chk({name, " tready mid"}, tready[u], 1);
            end
        end
        @(negedge clk);
        chk({name, " busy end"}, busy[u], 0);
        chk({name, " tx end"}, tx[u], 1);
    endtask

    // exp[23] is the first bit of the first frame
    task automatic b2b(input int u, input logic [7:0] d1, input logic [7:0] d2,
                       input logic [23:0] exp, input int flen, input string name);
        int div = divs[u];
        @(negedge clk);
        wait_ready(u, name);
        tdata[u]  = d1;
        tvalid[u] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        tdata[u] = d2;
        chk({name, " tready hold full"}, tready[u], 0);
        for (int c = 0; c < 2 * flen * div; c++) begin
            @(negedge clk);
            chk($sformatf("%s c=%0d", name, c), tx[u], exp[23 - c / div]);
            if (c == 0) chk({name, " tready c0"}, tready[u], 1);
            if (c == 1) begin
                chk({name, " tready c1"}, tready[u], 0);
                tvalid[u] = 1'b0;
            end
            if (c == flen * div - 1) chk({name, " tready end1"}, tready[u], 0);
            if (c == flen * div) chk({name, " tready start2"}, tready[u], 1);
        end
        @(negedge clk);
        chk({name, " busy end"}, busy[u], 0);
    endtask

    // receiver model for u0: 8 data bits, even parity, 1 stop, 4 cycles per bit, mid-bit sampling
    initial begin : rx_model
        logic [7:0] w;
        logic       p, s0, s1;
        forever begin
            @(negedge clk);
            if (rx_en && tx[0] === 1'b0) begin
                repeat (2) @(negedge clk);
                s0 = tx[0];
                for (int b = 0; b < 8; b++) begin
                    repeat (4) @(negedge clk);
                    w[b] = tx[0];
                end
                repeat (4) @(negedge clk);
                p = tx[0];
                repeat (4) @(negedge clk);
                s1 = tx[0];
                rx_cnt++;
                chk("rx start", {31'd0, s0}, 0);
                chk("rx parity", {31'd0, p}, {31'd0, ^w});
                chk("rx stop", {31'd0, s1}, 1);
                chk("rx queue nonempty", (sent_q.size() > 0), 1);
                if (sent_q.size() > 0) chk("rx data", w, sent_q.pop_front());
            end
        end
    end

    initial begin
        checks = 0;
        errors = 0;
        rx_cnt = 0;
        rx_en  = 1'b0;
        rst    = 1'b1;
        divs   = '{4, 4, 4, 1};
        for (int u = 0; u < 4; u++) begin
            tdata[u]  = 8'h00;
            tvalid[u] = 1'b0;
        end
        vecs[0]  = '{u:0, d:8'hA5, exp:12'b01010010101_0, nbits:11, name:"even A5"};
        vecs[1]  = '{u:0, d:8'h00, exp:12'b00000000001_0, nbits:11, name:"even 00"};
        vecs[2]  = '{u:0, d:8'hFF, exp:12'b01111111101_0, nbits:11, name:"even FF"};
        vecs[3]  = '{u:0, d:8'h01, exp:12'b01000000011_0, nbits:11, name:"even 01"};
        vecs[4]  = '{u:0, d:8'h80, exp:12'b00000000111_0, nbits:11, name:"even 80"};
        vecs[5]  = '{u:0, d:8'h3C, exp:12'b00011110001_0, nbits:11, name:"even 3C"};
        vecs[6]  = '{u:0, d:8'h07, exp:12'b01110000011_0, nbits:11, name:"even 07"};
        vecs[7]  = '{u:1, d:8'h00, exp:12'b00000000011_0, nbits:11, name:"odd 00"};
        vecs[8]  = '{u:1, d:8'h01, exp:12'b01000000001_0, nbits:11, name:"odd 01"};
        vecs[9]  = '{u:2, d:8'h81, exp:12'b0100000011_00, nbits:10, name:"nopar 81"};
        vecs[10] = '{u:2, d:8'h3C, exp:12'b0001111001_00, nbits:10, name:"nopar 3C"};
        vecs[11] = '{u:3, d:8'hA5, exp:12'b010100101011,  nbits:12, name:"div1 A5"};
        vecs[12] = '{u:3, d:8'h01, exp:12'b010000000111,  nbits:12, name:"div1 01"};

        repeat (3) @(negedge clk);
        for (int u = 0; u < 4; u++) begin
            chk($sformatf("reset tx u%0d", u), tx[u], 1);
            chk($sformatf("reset busy u%0d", u), busy[u], 0);
            chk($sformatf("reset tready u%0d", u), tready[u], 0);
        end
        rst = 1'b0;
        @(negedge clk);
        for (int u = 0; u < 4; u++) chk($sformatf("post-reset tready u%0d", u), tready[u], 1);

        foreach (vecs[i]) send_check(vecs[i].u, vecs[i].d, vecs[i].exp, vecs[i].nbits, vecs[i].name);

        b2b(0, 8'h00, 8'hFF, 24'b00000000001_01111111101_00, 11, "b2b even");
        b2b(3, 8'h55, 8'h0F, 24'b010101010011_011110000011, 12, "b2b div1");

        // reset during data bit 3 of a 0x00 frame with 0x33 waiting in hold
        @(negedge clk);
        tdata[0]  = 8'h00;
        tvalid[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        tdata[0] = 8'h33;
        for (int c = 0; c < 18; c++) begin
            @(negedge clk);
            if (c == 1) tvalid[0] = 1'b0;
        end
        chk("rst pre tx", tx[0], 0);
        chk("rst pre tready", tready[0], 0);
        chk("rst pre busy", busy[0], 1);
        rst = 1'b1;
        #1;
        chk("rst async tx", tx[0], 1);
        chk("rst async busy", busy[0], 0);
        chk("rst async tready", tready[0], 0);
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            chk($sformatf("rst quiet c=%0d", c), {31'd0, tx[0]} | {31'd0, busy[0]} << 1, 1);
        end
        chk("rst after tready", tready[0], 1);
        send_check(0, 8'hA5, 12'b01010010101_0, 11, "after rst A5");

        // random loopback
        rx_en = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            int gap;
            gap = ($urandom_range(0, 7) == 0) ? $urandom_range(40, 60) : $urandom_range(0, 2);
            repeat (gap) @(negedge clk);
            @(negedge clk);
            tdata[0]  = 8'($urandom);
            tvalid[0] = 1'b1;
            wait_ready(0, "lb");
            @(posedge clk);
            sent_q.push_back(tdata[0]);
            @(negedge clk);
            tvalid[0] = 1'b0;
        end
        for (int n = 0; n < 2000 && rx_cnt < 1000; n++) @(negedge clk);
        chk("lb received count", rx_cnt, 1000);
        chk("lb queue drained", sent_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
